// File: rtl/pkwars_vtiming.sv
// Video timing generator: derives a 1-in-8 pixel enable from MCLK and produces
// registered, mutually aligned counters, blanking, sync and line/frame strobes.
module pkwars_vtiming #(
  parameter int H_TOTAL  = 384,
  parameter int H_ACTIVE = 256,
  parameter int HS_START = 304,
  parameter int HS_WIDTH = 32,
  parameter int V_TOTAL  = 264,
  parameter int V_ACTIVE = 224,
  parameter int VS_START = 240,
  parameter int VS_WIDTH = 3
) (
  input  logic       MCLK,
  input  logic       RESET_N,
  output logic       PCE,
  output logic [8:0] HPOS,
  output logic [8:0] VPOS,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HSYNC_N,
  output logic       VSYNC_N,
  output logic       LINE_ST,
  output logic       FRAME_ST
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
  localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
  localparam logic [8:0] HS_LO  = 9'(HS_START);
  localparam logic [8:0] HS_HI  = 9'(HS_START + HS_WIDTH);
  localparam logic [8:0] VS_LO  = 9'(VS_START);
  localparam logic [8:0] VS_HI  = 9'(VS_START + VS_WIDTH);

  logic [2:0] div;
  logic [8:0] h_nxt;
  logic [8:0] v_nxt;
  logic       h_wrap;
  logic       v_wrap;

  function automatic logic in_window(input logic [8:0] pos, input logic [8:0] lo,
                                     input logic [8:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

  always_comb begin
    h_wrap = PCE && (HPOS == H_LAST);
    v_wrap = h_wrap && (VPOS == V_LAST);
    h_nxt  = HPOS;
    v_nxt  = VPOS;
    if (PCE) h_nxt = h_wrap ? 9'd0 : HPOS + 9'd1;
    if (h_wrap) v_nxt = v_wrap ? 9'd0 : VPOS + 9'd1;
  end

  // Decodes use the next-state counters so every registered output lines up
  // with the HPOS/VPOS presented in the same cycle.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div      <= 3'd0;
      PCE      <= 1'b0;
      HPOS     <= 9'd0;
      VPOS     <= 9'd0;
      HBLANK   <= 1'b0;
      VBLANK   <= 1'b0;
      HSYNC_N  <= 1'b1;
      VSYNC_N  <= 1'b1;
      LINE_ST  <= 1'b0;
      FRAME_ST <= 1'b0;
    end else begin
      div      <= div + 3'd1;
      PCE      <= (div == 3'd6);
      HPOS     <= h_nxt;
      VPOS     <= v_nxt;
      HBLANK   <= (h_nxt >= H_ACT);
      VBLANK   <= (v_nxt >= V_ACT);
      HSYNC_N  <= !in_window(h_nxt, HS_LO, HS_HI);
      VSYNC_N  <= !in_window(v_nxt, VS_LO, VS_HI);
      LINE_ST  <= h_wrap;
      FRAME_ST <= v_wrap;
    end
  end

endmodule

// File: tb/tb_pkwars_vtiming.sv
// Scoreboard bench for pkwars_vtiming: a default-size instance and a shrunken
// instance (so whole frames fit in a short run) are compared every cycle.
`timescale 1ns/1ps
module tb_pkwars_vtiming;

  localparam int SHT = 24, SHA = 16, SHS = 18, SHW = 3;
  localparam int SVT = 10, SVA = 6,  SVS = 7,  SVW = 2;
  localparam int SFRAME = SHT * SVT * 8;

  typedef struct packed {
    logic       pce;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       hblank;
    logic       vblank;
    logic       hsync_n;
    logic       vsync_n;
    logic       line_st;
    logic       frame_st;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       a_pce, a_hblank, a_vblank, a_hsync_n, a_vsync_n, a_line_st, a_frame_st;
  logic [8:0] a_hpos, a_vpos;
  logic       b_pce, b_hblank, b_vblank, b_hsync_n, b_vsync_n, b_line_st, b_frame_st;
  logic [8:0] b_hpos, b_vpos;

  pkwars_vtiming dut_a (
    .MCLK(clk), .RESET_N(rst_n), .PCE(a_pce), .HPOS(a_hpos), .VPOS(a_vpos),
    .HBLANK(a_hblank), .VBLANK(a_vblank), .HSYNC_N(a_hsync_n), .VSYNC_N(a_vsync_n),
    .LINE_ST(a_line_st), .FRAME_ST(a_frame_st)
  );

  pkwars_vtiming #(
    .H_TOTAL(SHT), .H_ACTIVE(SHA), .HS_START(SHS), .HS_WIDTH(SHW),
    .V_TOTAL(SVT), .V_ACTIVE(SVA), .VS_START(SVS), .VS_WIDTH(SVW)
  ) dut_b (
    .MCLK(clk), .RESET_N(rst_n), .PCE(b_pce), .HPOS(b_hpos), .VPOS(b_vpos),
    .HBLANK(b_hblank), .VBLANK(b_vblank), .HSYNC_N(b_hsync_n), .VSYNC_N(b_vsync_n),
    .LINE_ST(b_line_st), .FRAME_ST(b_frame_st)
  );

  out_t got_a, got_b;
  assign got_a = {a_pce, a_hpos, a_vpos, a_hblank, a_vblank, a_hsync_n, a_vsync_n,
                  a_line_st, a_frame_st};
  assign got_b = {b_pce, b_hpos, b_vpos, b_hblank, b_vblank, b_hsync_n, b_vsync_n,
                  b_line_st, b_frame_st};

  out_t exp_a[$];
  out_t exp_b[$];
  int   frame_marks[$];
  int   n = 0;
  int   errors = 0;
  int   checks = 0;
  event sample_now;

  // Outputs after k MCLK edges since reset release, from pixel/line arithmetic.
  function automatic out_t model(int k, int ht, int ha, int hs, int hw,
                                 int vt, int va, int vs, int vw);
    out_t o;
    int p, h, v;
    p = k / 8;
    h = p % ht;
    v = (p / ht) % vt;
    o.pce      = (k % 8 == 7);
    o.hpos     = 9'(h);
    o.vpos     = 9'(v);
    o.hblank   = (h >= ha);
    o.vblank   = (v >= va);
    o.hsync_n  = !(h >= hs && h < hs + hw);
    o.vsync_n  = !(v >= vs && v < vs + vw);
    o.line_st  = (k > 0) && (k % 8 == 0) && (h == 0);
    o.frame_st = o.line_st && (v == 0);
    return o;
  endfunction

  task automatic push_expected();
    exp_a.push_back(model(n, 384, 256, 304, 32, 264, 224, 240, 3));
    exp_b.push_back(model(n, SHT, SHA, SHS, SHW, SVT, SVA, SVS, SVW));
  endtask

  task automatic check_val(string nm, int got, int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  task automatic check_out(string nm, out_t got, out_t req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s at %0t: got pce=%b h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b ls=%b fs=%b, required pce=%b h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b ls=%b fs=%b",
               nm, $time, got.pce, got.hpos, got.vpos, got.hblank, got.vblank,
               got.hsync_n, got.vsync_n, got.line_st, got.frame_st,
               req.pce, req.hpos, req.vpos, req.hblank, req.vblank,
               req.hsync_n, req.vsync_n, req.line_st, req.frame_st);
    end
  endtask

  // Monitor: drains the scoreboard on each falling edge or on an off-edge probe.
  initial begin
    out_t ea, eb;
    forever begin
      @(negedge clk or sample_now);
      while (exp_a.size() > 0 && exp_b.size() > 0) begin
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        check_out("full_size", got_a, ea);
        check_out("small_size", got_b, eb);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) n++;
    push_expected();
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    n = 0;
    #1;
    push_expected();
    -> sample_now;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick();
    release_reset();

    for (int i = 0; i < 10000; i++) begin
      tick();
      #1;
      if (b_frame_st) frame_marks.push_back(n);
    end
    if (frame_marks.size() < 4) begin
      check_val("frame_pulse_count", frame_marks.size(), 4);
    end else begin
      for (int i = 1; i < 4; i++)
        check_val("frame_period", frame_marks[i] - frame_marks[i-1], SFRAME);
    end

    for (int r = 0; r < 4; r++) begin
      int run;
      run = $urandom_range(100, 4000);
      repeat (run) tick();
      async_reset();
      repeat ($urandom_range(1, 4)) tick();
      release_reset();
    end
    repeat (600) tick();

    @(negedge clk);
    #1;
    check_val("scoreboard_drained", exp_a.size() + exp_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

// File: doc/pkwars_vtiming.md
# pkwars_vtiming

Video timing generator clocked from the 48 MHz master clock. It derives a one-in-eight pixel clock enable (6 MHz) internally and produces the horizontal/vertical counters, blanking, sync, and line/frame strobes. Video, sprite, and VRAM logic consume these outputs, replacing free-running divided clocks with enables in the single MCLK domain. All outputs are registered and mutually aligned.

## Interface

Parameters:
- H_TOTAL, 384: pixels per line (count 0..H_TOTAL-1)
- H_ACTIVE, 256: visible pixels (HPOS 0..H_ACTIVE-1)
- HS_START, 304: HPOS at which HSYNC_N falls
- HS_WIDTH, 32: HSYNC_N low width in pixels
- V_TOTAL, 264: lines per frame
- V_ACTIVE, 224: visible lines
- VS_START, 240: VPOS at which VSYNC_N falls
- VS_WIDTH, 3: VSYNC_N low width in lines

Ports:
- MCLK  in  1  48 MHz master clock; the only clock
- RESET_N  in  1  asynchronous, active-low reset
- PCE  out  1  pixel clock enable, high one MCLK cycle in every 8
- HPOS  out  9  horizontal count
- VPOS  out  9  vertical count
- HBLANK  out  1  high when HPOS >= H_ACTIVE
- VBLANK  out  1  high when VPOS >= V_ACTIVE
- HSYNC_N  out  1  active-low horizontal sync
- VSYNC_N  out  1  active-low vertical sync
- LINE_ST  out  1  one-MCLK pulse coincident with the PCE that moves HPOS to 0
- FRAME_ST  out  1  one-MCLK pulse coincident with the PCE that moves HPOS and VPOS to 0

## Operation

- The 3-bit divider DIV increments every MCLK cycle and wraps 7→0.
- PCE is registered. It is high during the MCLK cycle after DIV==6 is sampled, so it is high exactly when DIV==7.
- On an MCLK edge where PCE is high:
  - HPOS advances.
  - At HPOS==H_TOTAL-1, HPOS wraps to 0 and VPOS advances.
  - At VPOS==V_TOTAL-1 together with the HPOS wrap, VPOS wraps to 0.
- HBLANK, VBLANK, HSYNC_N, and VSYNC_N are decoded from the next-state counter values and registered, so they always describe the HPOS/VPOS currently on the outputs. There is no extra lag.
- HSYNC_N is low for HS_START <= HPOS < HS_START+HS_WIDTH.
- VSYNC_N is low for VS_START <= VPOS < VS_START+VS_WIDTH, for whole lines. It changes only on the HPOS wrap.
- LINE_ST and FRAME_ST are high only in the MCLK cycle in which the new HPOS=0 (and VPOS=0 for FRAME_ST) first appears. They stay high for one MCLK cycle, not one pixel.
- Counters never exceed TOTAL-1. Out-of-range values are impossible after reset.
- Parameter legality: ACTIVE < SYNC start, and sync end <= TOTAL, for both axes. No runtime checking is done.

## Timing

- Reset values while RESET_N is low:
  - DIV=0, PCE=0, HPOS=0, VPOS=0
  - HBLANK=0, VBLANK=0, HSYNC_N=1, VSYNC_N=1
  - LINE_ST=0, FRAME_ST=0
- After RESET_N deasserts, the first PCE is high in the 8th MCLK cycle. Call it rising edge #8 (edge #1 is the first edge with RESET_N high).
- HPOS becomes 1 at the edge ending that PCE cycle.
- Reset is not re-synchronised internally. Asserting RESET_N mid-frame clears everything immediately (asynchronous). Restart behaves as a power-up.
- Nominal rates: 6 MHz pixel, 15.625 kHz line, 59.19 Hz frame. One frame is 384×264×8 = 811008 MCLK cycles.
- The PCE duty is exactly 1/8 with no jitter. Consecutive PCE pulses are 8 MCLK cycles apart.

## Test plan

- Reset release: count MCLK edges to the first PCE -> PCE high exactly at edge #8; then PCE period is 8 on every pulse for 1000 pulses; all outputs hold the reset values before the first PCE.
- Line wrap: run to HPOS=383 -> on the next PCE edge HPOS=0, VPOS+1, LINE_ST high for 1 MCLK cycle, HBLANK falls together with HPOS=0.
- Blank/sync windows: over one line -> HBLANK rises at HPOS=256; HSYNC_N is low for HPOS 304..335 (32 pixels, 256 MCLK cycles).
- Frame wrap: run to VPOS=263, HPOS=383 -> the next PCE gives VPOS=0, HPOS=0, FRAME_ST and LINE_ST both high for 1 cycle; VBLANK is high for VPOS 224..263; VSYNC_N is low for VPOS 240..242 only.
- Mid-frame reset: assert RESET_N low at VPOS=100, HPOS=50, off a clock edge -> all outputs reach reset values without waiting for an MCLK edge; after release the first PCE lands on edge #8 and HPOS counts from 0.
- Frame period: measure the FRAME_ST interval -> exactly 811008 MCLK cycles across 3 consecutive frames.
